// File: rtl/pool_max_reduce.sv
// Streaming signed max/min reducer for the pooling path.
// Each lane is reduced over WINDOW accepted beats; one registered result beat per window.
module pool_max_reduce #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int WINDOW     = 4,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        mode_min,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*DATA_WIDTH-1:0] s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [LANES*DATA_WIDTH-1:0] m_data,
    output logic                        m_mode,
    output logic [CNT_W-1:0]            beat_cnt
);

    localparam int BUS_W = LANES * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

    logic [BUS_W-1:0] acc_reg;
    logic             mode_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             m_valid_reg;
    logic [BUS_W-1:0] m_data_reg;
    logic             m_mode_reg;

    logic [BUS_W-1:0] red_next;
    logic [BUS_W-1:0] result_next;
    logic             result_mode_next;
    logic             accept;
    logic             first_beat;
    logic             last_beat;

    assign s_ready    = !m_valid_reg || m_ready;
    assign accept     = s_valid && s_ready;
    assign first_beat = (cnt_reg == '0);
    assign last_beat  = (cnt_reg == LAST_BEAT);

    // With WINDOW==1 the first beat is also the last, so the result is the raw input
    // and the mode comes straight from the port rather than the latched copy.
    assign result_mode_next = first_beat ? mode_min : mode_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] acc_lane;
            logic signed [DATA_WIDTH-1:0] in_lane;
            logic                         take_in;

            assign acc_lane = $signed(acc_reg[gi*DATA_WIDTH +: DATA_WIDTH]);
            assign in_lane  = $signed(s_data[gi*DATA_WIDTH +: DATA_WIDTH]);
            // Strict compare: ties keep the accumulator value.
            assign take_in  = mode_reg ? (in_lane < acc_lane) : (in_lane > acc_lane);

            assign red_next[gi*DATA_WIDTH +: DATA_WIDTH] = take_in ? in_lane : acc_lane;
            assign result_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                first_beat ? s_data[gi*DATA_WIDTH +: DATA_WIDTH]
                           : red_next[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            mode_reg    <= 1'b0;
            cnt_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_mode_reg  <= 1'b0;
        end else begin
            if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end

            if (clr) begin
                cnt_reg <= '0;
            end else if (accept) begin
                if (first_beat) begin
                    acc_reg  <= s_data;
                    mode_reg <= mode_min;
                end else begin
                    acc_reg <= red_next;
                end

                if (last_beat) begin
                    m_data_reg  <= result_next;
                    m_mode_reg  <= result_mode_next;
                    m_valid_reg <= 1'b1;
                    cnt_reg     <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign m_valid  = m_valid_reg;
    assign m_data   = m_data_reg;
    assign m_mode   = m_mode_reg;
    assign beat_cnt = cnt_reg;

endmodule

// File: doc/pool_max_reduce.md
Name: pool_max_reduce

Overview:
- Streaming signed max/min reducer for the pooling path of the YOLOv5 accelerator (SPPF and 2x2 max-pool windows).
- Accepts LANES parallel two's-complement fixed-point samples per beat over a valid/ready interface.
- Reduces each lane over WINDOW consecutive accepted beats and emits one registered result beat per window.
- Generalises the combinational signed pairwise max: parametrised width, lane count and window depth, selectable min mode, handshaked pipelining.

Parameters:
DATA_WIDTH, 16, sample width per lane, two's complement (sign bit = MSB, not a fixed bit 15)
LANES, 4, parallel independent channels per beat
WINDOW, 4, beats reduced per output; legal range 1..256
CNT_W, 8, width of beat counter; must satisfy 2**CNT_W >= WINDOW

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  synchronous abort of partial window (counter to 0); does not touch output register
mode_min  in  1  0 = max, 1 = min; sampled only on first beat of a window
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_data  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
m_valid  out  1  result valid
m_ready  in  1  result accepted by downstream
m_data  out  LANES*DATA_WIDTH  per-lane reduced result, same packing
m_mode  out  1  mode used for the result currently on m_data
beat_cnt  out  CNT_W  beats accepted in current partial window

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high, priority over all other inputs including clr.
- Reset values: m_valid=0, m_data=0, m_mode=0, beat_cnt=0, accumulator=0, latched mode=0. s_ready=1 on the cycle after reset.
- Accept: input beat accepted when s_valid && s_ready. Output consumed when m_valid && m_ready.
- s_ready = !m_valid || m_ready, combinational. Never depends on s_valid.
- Compare rule: signed two's-complement per lane.
  - Max mode: larger signed value wins. Min mode: smaller signed value wins.
  - Ties return the accumulator value (bit-identical either way).
  - Full range supported: most-negative value (0x8000 at 16 bits) and most-positive value (0x7FFF) compare correctly.
  - No saturation or rounding; results are always one of the inputs.
- Counter/accumulator on each accepted beat:
  - beat_cnt==0: accumulator <= s_data; latched mode <= mode_min.
  - Otherwise: accumulator <= cmp(accumulator, s_data) under the latched mode.
  - beat_cnt==WINDOW-1:
    - m_data <= cmp(accumulator, s_data), or s_data directly when WINDOW==1.
    - m_mode <= latched mode, or mode_min when beat_cnt==0.
    - m_valid <= 1; beat_cnt <= 0.
  - Otherwise: beat_cnt <= beat_cnt+1.
- Latency: result visible on m_data/m_valid the cycle after the final beat is accepted. Back-to-back windows at full throughput when m_ready is held high: one input beat per cycle, one output per WINDOW cycles.
- Output hold: while m_valid && !m_ready, m_data and m_mode are stable and s_ready=0. No beats are accepted, so no partial-window progress occurs.
- Simultaneous output consume and final-beat accept in the same cycle: m_valid stays 1 and m_data takes the new result.
- Output consume with no final beat: m_valid <= 0 next cycle.
- Mode changes mid-window are ignored until the next window's first beat.
- clr asserted:
  - beat_cnt <= 0 and any beat accepted in the same cycle is discarded. The accumulator content is don't-care, since it is overwritten on the next first beat.
  - m_valid/m_data are unaffected and still drain normally.
- rst mid-window or while m_valid=1: the partial window and the pending result are dropped, and all outputs return to reset values.

Test Plan:
- Signed max, DATA_WIDTH=16, LANES=1, WINDOW=4, mode_min=0, m_ready=1: beats 0xFFFE(-2), 0x0003, 0x8000, 0x7FFF -> one m_valid pulse one cycle after beat 4, m_data=0x7FFF, m_mode=0.
- Min mode with sign extremes: beats 0x0001, 0x8000, 0xFFFF, 0x0000 with mode_min=1 on beat 1 and toggled to 0 on beat 3 -> m_data=0x8000, m_mode=1.
- Backpressure, LANES=4: complete window with lane values {5,-5,0,-1}, {-7,9,0,-1}, {1,1,1,1}, {2,-9,-2,-3}; hold m_ready=0 for 5 cycles -> m_data lanes {5,9,1,1} held stable and s_ready=0 throughout; m_ready=1 -> consumed, s_ready=1 same cycle.
- Continuous stream, WINDOW=2, m_ready=1, 8 consecutive beats of values 1..8 -> four results 2,4,6,8 on cycles 2,4,6,8 after the first beat; no bubble on s_ready.
- clr after 2 of 4 beats (values 100, 200), then beats 1, 2, 3, 4 -> single result 4; the 100/200 never appear, beat_cnt returns to 0 on the clr cycle.
- rst asserted on cycle after a final beat while m_ready=0 -> m_valid=0, m_data=0, beat_cnt=0 next cycle; the following full window produces a correct result.
